// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Decodes the immediate of a RISC-V instruction word into a
//            sign-extended XLEN value, a format code and an illegal flag. The
//            result travels in a 2-entry FIFO (output register + skid
//            register) with a valid/ready handshake and an opaque tag.
// Ports    : clk, rst_n (async, active-low), flush (sync discard)
//            in_valid / in_ready / in_instr[31:0] / in_tag[TAG_W-1:0]
//            out_valid / out_ready / out_imm[XLEN-1:0] / out_fmt[2:0]
//            out_illegal / out_tag[TAG_W-1:0]
// Params   : XLEN (32 or 64), TAG_W
// Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;

    localparam bit c_RV64 = (XLEN == 64);

    // Payload layout: {tag, illegal, fmt, imm}
    localparam int c_DW = TAG_W + 4 + XLEN;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [c_DW-1:0] w_dec_data;

    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = c_FMT_NONE;
        w_illegal = 1'b0;
        // The full 7-bit match also rejects any word whose bits [1:0] are
        // not 2'b11, since every listed opcode ends in 2'b11.
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w_fmt   = c_FMT_I;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0011011: begin
                if (c_RV64) begin
                    w_fmt   = c_FMT_I;
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                w_fmt   = c_FMT_S;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = c_FMT_B;
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = c_FMT_U;
                w_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b1101111: begin
                w_fmt   = c_FMT_J;
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                // R-type: no immediate, but a legal instruction
            end
            7'b0111011: begin
                if (!c_RV64) begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit immediate above is already sign-correct in bit 31, so
    // widening to XLEN is a plain replication of that bit.
    generate
        if (XLEN > 32) begin : g_ext
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_noext
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_dec_data = {in_tag, w_illegal, w_fmt, w_imm};

    // ------------------------------------------------------------------
    // 2-entry FIFO control
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            r_in_ready;
    logic [c_DW-1:0] r_out_data;
    logic [c_DW-1:0] r_skid_data;

    logic w_accept;
    logic w_pop;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_out_load_dec;
    logic w_out_load_skid;
    logic w_skid_load;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_out_load_dec   = 1'b0;
        w_out_load_skid  = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                // Full: in_ready is low, so no accept can coincide here
                w_out_load_skid  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_out_load_dec   = 1'b1;
            end else begin
                w_out_valid_nxt  = 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                w_skid_load      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_out_load_dec   = 1'b1;
                w_out_valid_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Registered copy of "not full" keeps in_ready off the
            // out_ready combinational path.
            r_in_ready   <= ~w_skid_valid_nxt;
            if (w_out_load_dec) begin
                r_out_data <= w_dec_data;
            end else if (w_out_load_skid) begin
                r_out_data <= r_skid_data;
            end
            if (w_skid_load) begin
                r_skid_data <= w_dec_data;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_data[XLEN-1:0];
    assign out_fmt     = r_out_data[XLEN+2:XLEN];
    assign out_illegal = r_out_data[XLEN+3];
    assign out_tag     = r_out_data[c_DW-1:XLEN+4];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe. Drives an XLEN=64 and an
//            XLEN=32 instance from the same stimulus and compares both with
//            an arithmetic reference decoder and a queue-based FIFO model.
// Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [7:0]  in_tag = 8'd0;
    logic        out_ready = 1'b0;

    logic        in_ready,  out_valid,  out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  tag;
    } entry_t;

    entry_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Directed-value hook, consumed at the next sampling point
    logic        dchk = 1'b0;
    logic [63:0] d_imm64;
    logic [31:0] d_imm32;
    logic [2:0]  d_fmt;
    logic        d_ill;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    // Reference decoder written from the instruction-set field rules
    function automatic void ref_dec(input logic [31:0] ins, input bit is64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint x;
        longint s;
        x   = longint'($signed(ins));
        s   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0010011 || ins[6:0] == 7'b1100111 ||
            (is64 && ins[6:0] == 7'b0011011)) begin
            fmt = 3'd1; s = x >>> 20;
        end else if (ins[6:0] == 7'b0100011) begin
            fmt = 3'd2; s = ((x >>> 25) <<< 5) | longint'(ins[11:7]);
        end else if (ins[6:0] == 7'b1100011) begin
            fmt = 3'd3;
            s = ((x >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
        end else if (ins[6:0] == 7'b0110111 || ins[6:0] == 7'b0010111) begin
            fmt = 3'd4; s = (x >>> 12) <<< 12;
        end else if (ins[6:0] == 7'b1101111) begin
            fmt = 3'd5;
            s = ((x >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
        end else if (ins[6:0] == 7'b0110011 || (is64 && ins[6:0] == 7'b0111011)) begin
            fmt = 3'd0;
        end else begin
            ill = 1'b1;
        end
        imm = 64'(s);
    endfunction

    task automatic check_outputs();
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic        exp_rdy;
        logic        exp_vld;
        exp_rdy = (q.size() < 2);
        exp_vld = (q.size() > 0);
        chk("in_ready64",  {63'd0, in_ready},    {63'd0, exp_rdy});
        chk("in_ready32",  {63'd0, in_ready32},  {63'd0, exp_rdy});
        chk("out_valid64", {63'd0, out_valid},   {63'd0, exp_vld});
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, exp_vld});
        if (exp_vld) begin
            ref_dec(q[0].instr, 1'b1, imm, fmt, ill);
            chk("imm64", out_imm, imm);
            chk("fmt64", {61'd0, out_fmt}, {61'd0, fmt});
            chk("ill64", {63'd0, out_illegal}, {63'd0, ill});
            chk("tag64", {56'd0, out_tag}, {56'd0, q[0].tag});
            ref_dec(q[0].instr, 1'b0, imm, fmt, ill);
            chk("imm32", {32'd0, out_imm32}, {32'd0, imm[31:0]});
            chk("fmt32", {61'd0, out_fmt32}, {61'd0, fmt});
            chk("ill32", {63'd0, out_illegal32}, {63'd0, ill});
            chk("tag32", {56'd0, out_tag32}, {56'd0, q[0].tag});
        end
        if (dchk) begin
            chk("dir_valid", {63'd0, out_valid}, 64'd1);
            chk("dir_imm64", out_imm, d_imm64);
            chk("dir_imm32", {32'd0, out_imm32}, {32'd0, d_imm32});
            chk("dir_fmt",   {61'd0, out_fmt}, {61'd0, d_fmt});
            chk("dir_ill",   {63'd0, out_illegal}, {63'd0, d_ill});
            dchk = 1'b0;
        end
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                         input logic rdy, input logic fl);
        bit     acc;
        bit     pop;
        entry_t e;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check_outputs();
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.instr = ins;
                e.tag   = tg;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic directed(input logic [31:0] ins, input logic [7:0] tg,
                            input logic [63:0] e64, input logic [31:0] e32,
                            input logic [2:0] efmt, input logic eill);
        cycle(1'b1, ins, tg, 1'b1, 1'b0);
        d_imm64 = e64;
        d_imm32 = e32;
        d_fmt   = efmt;
        d_ill   = eill;
        dchk    = 1'b1;
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid64", {63'd0, out_valid},   64'd0);
        chk("rst_imm64",   out_imm,              64'd0);
        chk("rst_fmt64",   {61'd0, out_fmt},     64'd0);
        chk("rst_ill64",   {63'd0, out_illegal}, 64'd0);
        chk("rst_tag64",   {56'd0, out_tag},     64'd0);
        chk("rst_valid32", {63'd0, out_valid32}, 64'd0);
        chk("rst_imm32",   {32'd0, out_imm32},   64'd0);
        chk("rst_tag32",   {56'd0, out_tag32},   64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011, 7'b0000000};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = ops[$urandom_range(0, 10)];
        end
        return w;
    endfunction

    initial begin
        // Asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed immediates
        directed(32'hFFF02083, 8'h11, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0);
        directed(32'hFE000EE3, 8'h12, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd3, 1'b0);
        directed(32'h0010006F, 8'h13, 64'h0000000000000800, 32'h00000800, 3'd5, 1'b0);
        directed(32'h800000B7, 8'h14, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 1'b0);
        directed(32'h0000007F, 8'h15, 64'd0, 32'd0, 3'd0, 1'b1);

        // Backpressure: three back-to-back inputs, only two fit
        cycle(1'b1, 32'h00100093, 8'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 8'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 8'd3, 1'b0, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300093, 8'd3, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

        // Flush while full, with an input in the flush cycle
        cycle(1'b1, 32'h00500013, 8'd5, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600013, 8'd6, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700013, 8'd7, 1'b0, 1'b1);
        chk("flush_valid",    {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready},  64'd1);
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

        // Reset mid-stream with both entries occupied
        cycle(1'b1, 32'hABCDE037, 8'd8, 1'b0, 1'b0);
        cycle(1'b1, 32'h1234506F, 8'd9, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

        // Throughput with out_ready held high
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, rand_instr(), 8'(8'h40 + i), 1'b1, 1'b0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_instr(), 8'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 40) == 0);
        end

        // Drain
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
